// File: rtl/piano_pkg.sv
// Shared definitions for the piano keyboard front end and the tone divider:
// note codes, encoder FSM states and a lowest-set-bit helper.
package piano_pkg;

    localparam logic [2:0] DO4  = 3'd0;
    localparam logic [2:0] RE4  = 3'd1;
    localparam logic [2:0] MI4  = 3'd2;
    localparam logic [2:0] FA4  = 3'd3;
    localparam logic [2:0] SOL4 = 3'd4;
    localparam logic [2:0] LA4  = 3'd5;
    localparam logic [2:0] SI4  = 3'd6;
    localparam logic [2:0] DO5  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_SUSTAIN = 2'd2
    } key_state_e;

    // Returns the index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a stability counter that only
// accepts a new level after it has been held for DEBOUNCE_CYCLES cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic key_db_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= key_raw_i;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign key_db_o = db_q;

endmodule

// File: rtl/piano_key_encoder.sv
// Eight debounced piano keys to a 3-bit note code with last-note priority,
// a gate for the tone output and a release sustain timer.
module piano_key_encoder
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SUSTAIN_CYCLES  = 12500000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] keys_raw,
    output logic [2:0] note,
    output logic       gate,
    output logic       note_change,
    output logic [7:0] keys_db
);

    localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
    localparam logic [SUS_W-1:0] SUS_MAX = SUS_W'(SUSTAIN_CYCLES - 1);

    key_state_e       state_q;
    key_state_e       state_d;
    logic [2:0]       note_q;
    logic [2:0]       note_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [SUS_W-1:0] sus_cnt_q;
    logic [SUS_W-1:0] sus_cnt_d;
    logic [7:0]       keys_db_q;
    logic [7:0]       press;
    logic [2:0]       press_note;
    logic [2:0]       held_note;

    for (genvar i = 0; i < 8; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i    (clk_in),
            .rst_i    (rst),
            .key_raw_i(keys_raw[i]),
            .key_db_o (keys_db[i])
        );
    end

    assign press      = keys_db & ~keys_db_q;
    assign press_note = first_set(press);
    assign held_note  = first_set(keys_db);

    // Presses always win over releases seen in the same cycle.
    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        pulse_d   = 1'b0;
        sus_cnt_d = sus_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (press != 8'd0) begin
                    state_d = ST_PLAY;
                    note_d  = press_note;
                    pulse_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (press != 8'd0) begin
                    note_d  = press_note;
                    pulse_d = (press_note != note_q);
                end else if (keys_db == 8'd0) begin
                    state_d   = ST_SUSTAIN;
                    sus_cnt_d = '0;
                end else if (!keys_db[note_q]) begin
                    note_d  = held_note;
                    pulse_d = (held_note != note_q);
                end
            end
            ST_SUSTAIN: begin
                if (press != 8'd0) begin
                    state_d   = ST_PLAY;
                    note_d    = press_note;
                    pulse_d   = (press_note != note_q);
                    sus_cnt_d = '0;
                end else if (sus_cnt_q == SUS_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    sus_cnt_d = sus_cnt_q + SUS_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            note_q    <= 3'd0;
            pulse_q   <= 1'b0;
            sus_cnt_q <= '0;
            keys_db_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            pulse_q   <= pulse_d;
            sus_cnt_q <= sus_cnt_d;
            keys_db_q <= keys_db;
        end
    end

    assign note        = note_q;
    assign gate        = (state_q != ST_IDLE);
    assign note_change = pulse_q;

endmodule
